// File: rtl/pong_frame_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pong_frame_renderer                                    |
// | Description : Two-player Pong. Game state advances once per frame    |
// |               (falling vsync_in edge seen on pixel_en); colour and   |
// |               syncs are registered one pixel_en cycle after inputs.  |
// | Option      : PONG_SCORE_EN - scoring with SCORED/OVER states. When  |
// |               undefined, scores read 0 and side walls reflect ball.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pong_frame_renderer #(
  parameter int XRES      = 640,
  parameter int YRES      = 480,
  parameter int PADDLE_H  = 64,
  parameter int PADDLE_W  = 8,
  parameter int BALL_SIZE = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pixel_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] xposition,
  input  logic [9:0] yposition,
  input  logic       l_up,
  input  logic       l_dn,
  input  logic       r_up,
  input  logic       r_dn,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [3:0] score_l,
  output logic [3:0] score_r
);

  localparam logic [10:0] c_xres     = 11'(XRES);
  localparam logic [10:0] c_yres     = 11'(YRES);
  localparam logic [10:0] c_pad_h    = 11'(PADDLE_H);
  localparam logic [10:0] c_pad_w    = 11'(PADDLE_W);
  localparam logic [10:0] c_ball     = 11'(BALL_SIZE);
  localparam logic [10:0] c_pad_max  = 11'(YRES - PADDLE_H);
  localparam logic [10:0] c_lpad_x   = 11'd16;
  localparam logic [10:0] c_lface    = 11'(16 + PADDLE_W);
  localparam logic [10:0] c_rface    = 11'(XRES - 16 - PADDLE_W);
  localparam logic [9:0]  c_ball_x0  = 10'((XRES - BALL_SIZE) / 2);
  localparam logic [9:0]  c_ball_y0  = 10'((YRES - BALL_SIZE) / 2);
  localparam logic [9:0]  c_pad_y0   = 10'((YRES - PADDLE_H) / 2);
  localparam logic [5:0]  c_serve_last = 6'd59;

`ifdef PONG_SCORE_EN
  localparam logic [5:0]  c_scored_last = 6'd29;
  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, SCORED = 2'd2, OVER = 2'd3} state_t;
`else
  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1} state_t;
`endif

  state_t      r_state, w_state;
  logic [5:0]  r_cnt, w_cnt;
  logic [9:0]  r_ly, w_ly, r_ry, w_ry;
  logic [9:0]  r_bx, w_bx, r_by, w_by;
  logic        r_vx_neg, w_vx_neg, r_vy_neg, w_vy_neg;
  logic        r_vsync_d;
  logic [11:0] r_colour;
  logic        r_hsync, r_vsync;

  logic        w_tick, w_hidden, w_white;
  logic [10:0] w_bx_mv, w_by_mv, w_x, w_y;
  logic        w_wall_top, w_wall_bot, w_out_l, w_out_r, w_hit_l, w_hit_r;
  logic        w_on_lpad, w_on_rpad, w_on_ball;

  // Paddle step of 4 px, clamped to the visible height; both buttons cancel.
  function automatic logic [9:0] f_move_paddle(input logic [9:0] y, input logic up,
                                               input logic dn);
    logic [10:0] sum;
    sum = {1'b0, y} + 11'd4;
    f_move_paddle = y;
    if (up && !dn)
      f_move_paddle = (y < 10'd4) ? 10'd0 : y - 10'd4;
    else if (dn && !up)
      f_move_paddle = (sum > c_pad_max) ? c_pad_max[9:0] : sum[9:0];
  endfunction

  assign w_tick = pixel_en && r_vsync_d && !vsync_in;

  // Candidate ball position; a leftward/upward move saturates at 0 rather than wrapping.
  assign w_bx_mv = r_vx_neg ? ((r_bx < 10'd2) ? 11'd0 : {1'b0, r_bx} - 11'd2)
                            : {1'b0, r_bx} + 11'd2;
  assign w_by_mv = r_vy_neg ? ((r_by < 10'd2) ? 11'd0 : {1'b0, r_by} - 11'd2)
                            : {1'b0, r_by} + 11'd2;

  assign w_wall_top = (w_by_mv <= 11'd1);
  assign w_wall_bot = (w_by_mv + c_ball >= c_yres - 11'd1);
  assign w_out_l    = (w_bx_mv <= 11'd1);
  assign w_out_r    = (w_bx_mv + c_ball >= c_xres - 11'd1);

  // Paddle hits: ball edge within 2 px of the paddle face and any row overlap.
  assign w_hit_l = (w_bx_mv + 11'd2 >= c_lface) && (w_bx_mv <= c_lface + 11'd2) &&
                   (w_by_mv <= {1'b0, r_ly} + c_pad_h - 11'd1) &&
                   (w_by_mv + c_ball - 11'd1 >= {1'b0, r_ly});
  assign w_hit_r = (w_bx_mv + c_ball + 11'd2 >= c_rface) &&
                   (w_bx_mv + c_ball <= c_rface + 11'd2) &&
                   (w_by_mv <= {1'b0, r_ry} + c_pad_h - 11'd1) &&
                   (w_by_mv + c_ball - 11'd1 >= {1'b0, r_ry});

`ifdef PONG_SCORE_EN
  logic [3:0] r_score_l, w_score_l, r_score_r, w_score_r;
  assign w_hidden = (r_state == SCORED) || (r_state == OVER);
  assign score_l  = r_score_l;
  assign score_r  = r_score_r;
`else
  assign w_hidden = 1'b0;
  assign score_l  = 4'd0;
  assign score_r  = 4'd0;
`endif

  // Next game state; everything holds unless a frame tick arrives.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_ly     = r_ly;
    w_ry     = r_ry;
    w_bx     = r_bx;
    w_by     = r_by;
    w_vx_neg = r_vx_neg;
    w_vy_neg = r_vy_neg;
`ifdef PONG_SCORE_EN
    w_score_l = r_score_l;
    w_score_r = r_score_r;
`endif
    if (w_tick) begin
      w_ly = f_move_paddle(r_ly, l_up, l_dn);
      w_ry = f_move_paddle(r_ry, r_up, r_dn);
      case (r_state)
        SERVE: begin
          w_bx = c_ball_x0;
          w_by = c_ball_y0;
          if (r_cnt == c_serve_last) begin
            w_state = PLAY;
            w_cnt   = 6'd0;
          end else begin
            w_cnt = r_cnt + 6'd1;
          end
        end
        PLAY: begin
          w_bx = w_bx_mv[9:0];
          w_by = w_by_mv[9:0];
          if (w_wall_top)      w_vy_neg = 1'b0;
          else if (w_wall_bot) w_vy_neg = 1'b1;
          if (w_hit_l)         w_vx_neg = 1'b0;
          else if (w_hit_r)    w_vx_neg = 1'b1;
`ifdef PONG_SCORE_EN
          // Serve goes back toward whoever conceded the point.
          if (w_out_l) begin
            w_score_r = r_score_r + 4'd1;
            w_vx_neg  = 1'b1;
            w_cnt     = 6'd0;
            w_state   = (r_score_r == 4'd8) ? OVER : SCORED;
          end else if (w_out_r) begin
            w_score_l = r_score_l + 4'd1;
            w_vx_neg  = 1'b0;
            w_cnt     = 6'd0;
            w_state   = (r_score_l == 4'd8) ? OVER : SCORED;
          end
`else
          if (w_out_l)      w_vx_neg = 1'b0;
          else if (w_out_r) w_vx_neg = 1'b1;
`endif
        end
`ifdef PONG_SCORE_EN
        SCORED: begin
          if (r_cnt == c_scored_last) begin
            w_state = SERVE;
            w_cnt   = 6'd0;
            w_bx    = c_ball_x0;
            w_by    = c_ball_y0;
          end else begin
            w_cnt = r_cnt + 6'd1;
          end
        end
        OVER: w_state = OVER;
`endif
        default: w_state = SERVE;
      endcase
    end
  end

  // Game state register, advanced only on pixel_en.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= SERVE;
      r_cnt     <= 6'd0;
      r_ly      <= c_pad_y0;
      r_ry      <= c_pad_y0;
      r_bx      <= c_ball_x0;
      r_by      <= c_ball_y0;
      r_vx_neg  <= 1'b0;
      r_vy_neg  <= 1'b0;
      r_vsync_d <= 1'b1;
    end else if (pixel_en) begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_ly      <= w_ly;
      r_ry      <= w_ry;
      r_bx      <= w_bx;
      r_by      <= w_by;
      r_vx_neg  <= w_vx_neg;
      r_vy_neg  <= w_vy_neg;
      r_vsync_d <= vsync_in;
    end
  end

`ifdef PONG_SCORE_EN
  // Score registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_score_l <= 4'd0;
      r_score_r <= 4'd0;
    end else if (pixel_en) begin
      r_score_l <= w_score_l;
      r_score_r <= w_score_r;
    end
  end
`endif

  assign w_x = {1'b0, xposition};
  assign w_y = {1'b0, yposition};

  assign w_on_lpad = (w_x >= c_lpad_x) && (w_x < c_lface) &&
                     (w_y >= {1'b0, r_ly}) && (w_y < {1'b0, r_ly} + c_pad_h);
  assign w_on_rpad = (w_x >= c_rface) && (w_x < c_rface + c_pad_w) &&
                     (w_y >= {1'b0, r_ry}) && (w_y < {1'b0, r_ry} + c_pad_h);
  assign w_on_ball = !w_hidden &&
                     (w_x >= {1'b0, r_bx}) && (w_x < {1'b0, r_bx} + c_ball) &&
                     (w_y >= {1'b0, r_by}) && (w_y < {1'b0, r_by} + c_ball);
  assign w_white   = (w_x < c_xres) && (w_y < c_yres) && (w_on_lpad || w_on_rpad || w_on_ball);

  // Output stage: colour and syncs delayed together by one pixel_en.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_colour <= 12'h000;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
    end else if (pixel_en) begin
      r_colour <= w_white ? 12'hFFF : 12'h000;
      r_hsync  <= hsync_in;
      r_vsync  <= vsync_in;
    end
  end

  assign red       = r_colour[11:8];
  assign green     = r_colour[7:4];
  assign blue      = r_colour[3:0];
  assign hsync_out = r_hsync;
  assign vsync_out = r_vsync;

endmodule
`default_nettype wire

// File: tb/tb_pong_frame_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pong_frame_renderer                                 |
// | Description : Directed bench: first-frame pixel table, latency,      |
// |               paddle clamps, wall/paddle bounces, scoring and reset. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_pong_frame_renderer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       pixel_en = 1'b0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic [9:0] xposition = 10'd16;
  logic [9:0] yposition = 10'd240;
  logic       l_up = 1'b0, l_dn = 1'b0, r_up = 1'b0, r_dn = 1'b0;
  logic [3:0] red, green, blue, score_l, score_r;
  logic       hsync_out, vsync_out;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_n   = 0;

  typedef struct {
    int x;
    int y;
    bit hs;
    bit white;
  } vec_t;
  vec_t vecs[17];

  always #5 clock = ~clock;

  pong_frame_renderer dut (
    .clock(clock), .reset(reset), .pixel_en(pixel_en),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .xposition(xposition), .yposition(yposition),
    .l_up(l_up), .l_dn(l_dn), .r_up(r_up), .r_dn(r_dn),
    .red(red), .green(green), .blue(blue),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .score_l(score_l), .score_r(score_r)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One pixel_en pulse every 4th clock; returns at the negedge after it.
  task automatic step();
    repeat (3) @(negedge clock);
    pixel_en = 1'b1;
    @(negedge clock);
    pixel_en = 1'b0;
  endtask

  task automatic tick();
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
    tick_n++;
  endtask

  task automatic ticks(input int count);
    for (int i = 0; i < count; i++) tick();
  endtask

  task automatic probe(input string name, input int x, input int y, input bit white);
    xposition = 10'(x);
    yposition = 10'(y);
    step();
    check(name, int'({red, green, blue}), white ? 32'hFFF : 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    vsync_in = 1'b1;
    hsync_in = 1'b1;
    {l_up, l_dn, r_up, r_dn} = 4'b0000;
    step();
    step();
    @(negedge clock);
    reset = 1'b1;
    tick_n = 0;
  endtask

  initial begin
    vecs[0]  = '{16, 208, 1'b1, 1'b1};
    vecs[1]  = '{16, 207, 1'b0, 1'b0};
    vecs[2]  = '{23, 271, 1'b1, 1'b1};
    vecs[3]  = '{23, 272, 1'b0, 1'b0};
    vecs[4]  = '{15, 240, 1'b1, 1'b0};
    vecs[5]  = '{24, 240, 1'b1, 1'b0};
    vecs[6]  = '{616, 208, 1'b0, 1'b1};
    vecs[7]  = '{623, 271, 1'b1, 1'b1};
    vecs[8]  = '{615, 240, 1'b0, 1'b0};
    vecs[9]  = '{624, 240, 1'b1, 1'b0};
    vecs[10] = '{316, 236, 1'b0, 1'b1};
    vecs[11] = '{323, 243, 1'b1, 1'b1};
    vecs[12] = '{315, 240, 1'b0, 1'b0};
    vecs[13] = '{324, 240, 1'b1, 1'b0};
    vecs[14] = '{320, 235, 1'b1, 1'b0};
    vecs[15] = '{320, 244, 1'b0, 1'b0};
    vecs[16] = '{700, 240, 1'b1, 1'b0};

    // Held in reset with a paddle pixel and low syncs presented.
    step();
    step();
    check("reset rgb", int'({red, green, blue}), 0);
    check("reset hsync_out", int'(hsync_out), 1);
    check("reset vsync_out", int'(vsync_out), 1);
    check("reset score_l", int'(score_l), 0);
    check("reset score_r", int'(score_r), 0);

    do_reset();

    // First-frame pixel table.
    for (int i = 0; i < 17; i++) begin
      xposition = 10'(vecs[i].x);
      yposition = 10'(vecs[i].y);
      hsync_in  = vecs[i].hs;
      step();
      check($sformatf("vec%0d rgb", i), int'({red, green, blue}), vecs[i].white ? 32'hFFF : 32'h0);
      check($sformatf("vec%0d hsync", i), int'(hsync_out), int'(vecs[i].hs));
      check($sformatf("vec%0d vsync", i), int'(vsync_out), 1);
    end

    // Outputs move only on pixel_en.
    hsync_in = 1'b1;
    probe("lat white", 16, 240, 1'b1);
    xposition = 10'd0;
    hsync_in  = 1'b0;
    repeat (2) @(negedge clock);
    check("lat hold rgb", int'({red, green, blue}), 32'hFFF);
    check("lat hold hsync", int'(hsync_out), 1);
    step();
    check("lat rgb", int'({red, green, blue}), 0);
    check("lat hsync", int'(hsync_out), 0);
    hsync_in = 1'b1;

    // Run 1: left paddle to top, right paddle to bottom during serve.
    l_up = 1'b1;
    r_dn = 1'b1;
    tick();
    check("vsync_out follows", int'(vsync_out), 0);
    ticks(59);
    l_up = 1'b0;
    r_dn = 1'b0;
    probe("lpad top row", 16, 0, 1'b1);
    probe("lpad row 63", 16, 63, 1'b1);
    probe("lpad row 64", 16, 64, 1'b0);
    probe("rpad row 415", 616, 415, 1'b0);
    probe("rpad row 416", 616, 416, 1'b1);
    probe("rpad row 479", 623, 479, 1'b1);
    probe("serve ball held", 316, 236, 1'b1);

    l_up = 1'b1;
    l_dn = 1'b1;
    tick();
    l_up = 1'b0;
    probe("both btn lpad 0", 16, 0, 1'b1);
    probe("both btn lpad 64", 16, 64, 1'b0);
    probe("play first move", 318, 238, 1'b1);
    probe("play first move left", 317, 238, 1'b0);

    ticks(35);
    l_dn = 1'b0;
    probe("lpad 139", 16, 139, 1'b0);
    probe("lpad 140", 16, 140, 1'b1);

    ticks(317);
    probe("ball y2", 190, 2, 1'b1);
    probe("ball y2 above", 190, 1, 1'b0);
    tick();
    probe("ball y0", 188, 0, 1'b1);
    probe("ball y0 below", 188, 8, 1'b0);
    tick();
    probe("ball y2 after bounce", 186, 2, 1'b1);
    probe("ball y2 after bounce above", 186, 1, 1'b0);

    ticks(80);
    probe("ball at lface", 26, 162, 1'b1);
    probe("ball at lface left", 25, 162, 1'b0);
    tick();
    probe("ball after lhit", 28, 164, 1'b1);
    probe("ball after lhit left", 27, 164, 1'b0);

    // Asynchronous reset mid-frame.
    probe("pre reset white", 16, 150, 1'b1);
    hsync_in = 1'b0;
    step();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("async reset rgb", int'({red, green, blue}), 0);
    check("async reset hsync", int'(hsync_out), 1);
    do_reset();
    probe("post reset lpad 208", 16, 208, 1'b1);
    probe("post reset lpad 150", 16, 150, 1'b0);

    // Run 2: only the right paddle moves; ball misses on the left.
    r_dn = 1'b1;
    ticks(60);
    r_dn = 1'b0;
    ticks(447);
    probe("ball x2 before miss", 2, 186, 1'b1);
    check("score_r before miss", int'(score_r), 0);
    tick();
`ifdef PONG_SCORE_EN
    check("score_r after miss", int'(score_r), 1);
    check("score_l after miss", int'(score_l), 0);
    probe("ball hidden scored", 0, 188, 1'b0);
    ticks(29);
    probe("still scored", 316, 236, 1'b0);
    tick();
    probe("serve after scored", 316, 236, 1'b1);
    ticks(60);
    tick();
    probe("serve toward left", 314, 238, 1'b1);
    probe("serve toward left edge", 322, 238, 1'b0);

    for (int i = 0; i < 3000 && score_r != 4'd9; i++) tick();
    check("score_r reaches 9", int'(score_r), 9);
    check("tick of ninth point", tick_n, 2492);
    check("score_l in over", int'(score_l), 0);
    probe("over ball hidden", 0, 80, 1'b0);
    probe("over centre dark", 316, 236, 1'b0);
    l_up = 1'b1;
    tick();
    l_up = 1'b0;
    probe("over paddle moves", 16, 204, 1'b1);
    ticks(100);
    probe("over stays hidden", 316, 236, 1'b0);
    check("over score held", int'(score_r), 9);
`else
    probe("wall ball x0", 0, 188, 1'b1);
    check("no score_r", int'(score_r), 0);
    tick();
    probe("wall reflect", 2, 190, 1'b1);
    probe("wall reflect left", 1, 190, 1'b0);
    ticks(100);
    check("no score_l later", int'(score_l), 0);
    check("no score_r later", int'(score_r), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pong_frame_renderer.md
PONG_FRAME_RENDERER -- requirements
Module: pong_frame_renderer

Interface
REQ-001 Parameter XRES, default 640, visible width in pixels.
REQ-002 Parameter YRES, default 480, visible height in pixels.
REQ-003 Parameter PADDLE_H, default 64; PADDLE_W, default 8; BALL_SIZE, default 8; all in pixels.
REQ-004 Port clock, input, 1, system clock; the block has exactly one clock.
REQ-005 Port reset, input, 1, asynchronous, active-low reset.
REQ-006 Port pixel_en, input, 1, one-cycle pixel-rate enable; all state advances only when pixel_en=1, except reset.
REQ-007 Ports hsync_in and vsync_in, input, 1 each, active-low sync pulses from the CRT controller.
REQ-008 Ports xposition and yposition, input, 10 each, current scan coordinates.
REQ-009 Ports l_up, l_dn, r_up, r_dn, input, 1 each, synchronous paddle buttons, active-high.
REQ-010 Ports red, green, blue, output, 4 each, registered pixel colour.
REQ-011 Ports hsync_out and vsync_out, output, 1 each, sync inputs delayed to align with colour.
REQ-012 Ports score_l and score_r, output, 4 each, BCD scores from 0 to 9.

Function
REQ-013 Frame tick is the 1->0 transition of vsync_in, sampled on pixel_en; all game state updates exactly once per frame tick.
REQ-014 Paddle Y changes by 4 px per tick; up decrements, down increments, both pressed means no move; the result is clamped to 0..YRES-PADDLE_H.
REQ-015 Left paddle occupies x 16..16+PADDLE_W-1; right paddle occupies x XRES-16-PADDLE_W..XRES-17.
REQ-016 Ball moves by vx, vy = +/-2 px per tick; positions are 10-bit unsigned and the comparison is done before the add, so no wrap occurs.
REQ-017 If ball_y<=1 then vy becomes +2; if ball_y+BALL_SIZE>=YRES-1 then vy becomes -2.
REQ-018 Paddle hit: the ball's x edge is within 2 px of the paddle face and the ball overlaps the paddle Y range (inclusive); vx is then set away from that paddle.
REQ-019 A wall reflection and a paddle reflection in the same tick are both applied.
REQ-020 The FSM has states SERVE, PLAY, SCORED and OVER.
REQ-021 SERVE: the ball is held at ((XRES-BALL_SIZE)/2, (YRES-BALL_SIZE)/2); after 60 ticks go to PLAY.
REQ-022 PLAY: the ball moves; when ball_x<=1 the right player scores, and when ball_x+BALL_SIZE>=XRES-1 the left player scores; either goes to SCORED.
REQ-023 SCORED: the ball is hidden; after 30 ticks go to SERVE with vx directed toward the player who conceded.
REQ-024 Any score reaching 9 goes to OVER; the ball is frozen and hidden, paddles still move, and only reset exits OVER.
REQ-025 Colour is white (F,F,F) where (x,y) lies inside the ball (not hidden) or either paddle; it is black elsewhere, and forced black when x>=XRES or y>=YRES.
REQ-026 Colour and sync outputs have a latency of exactly one pixel_en cycle from their xposition/yposition/sync inputs.

Reset
REQ-027 While reset=0 the outputs are: red, green and blue = 0; hsync_out and vsync_out = 1; score_l and score_r = 0.
REQ-028 While reset=0 the state is: FSM = SERVE, frame counter = 0, paddles = (YRES-PADDLE_H)/2, ball centred, vx=+2, vy=+2.
REQ-029 Reset asserted mid-frame or mid-state takes effect immediately and asynchronously; on release, operation resumes at the next pixel_en.

Configuration
REQ-030 When macro PONG_SCORE_EN is defined, REQ-012, REQ-022 scoring, and REQ-023 and REQ-024 apply.
REQ-031 When PONG_SCORE_EN is undefined, score_l and score_r are tied to 0, the SCORED and OVER states are absent, and the side walls reflect vx as in REQ-017.

Verification
REQ-032 Release reset, feed 640x480 scan with pixel_en every 4th clock, no buttons -> first frame shows 64-line paddles at y 208..271 and ball at (316,236); outputs are 0 during reset.
REQ-033 Hold l_up for 60 frames -> left paddle Y=0 and stays 0; press l_up and l_dn together -> Y unchanged.
REQ-034 Preload ball at y=2 with vy=-2 in PLAY -> next tick ball_y=0 with vy=+2; the following tick gives ball_y=2.
REQ-035 Ball approaches the left face with the paddle overlapping in Y -> vx flips to +2; with the paddle moved away, ball_x<=1 -> score_r=1, ball hidden for 30 ticks, SERVE with vx=-2 (PONG_SCORE_EN defined).
REQ-036 Force score_l to 9 -> OVER, ball hidden, paddles still respond; without PONG_SCORE_EN the same miss reflects the ball and scores stay 0.
